// File: rtl/reg_dump_tx_pkg.sv
// reg_dump_pkg: shared FSM states, frame defaults and frame-size helpers for reg_dump_tx.
package reg_dump_pkg;
   typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   function automatic int frame_bytes(input int num_regs, input int word_w = 32);
      return 2 + (word_w / 8) * (num_regs + 1) + 1;
   endfunction
   function automatic int idx_w(input int num_regs, input int word_w = 32);
      return $clog2(frame_bytes(num_regs, word_w));
   endfunction
endpackage

// File: rtl/reg_dump_tx_if.sv
// reg_dump_tx_if: valid/ready byte stream from the dump stage to its sink.
interface reg_dump_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   modport master (output tx_data, tx_valid, input tx_ready);
   modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/reg_dump_tx_shadow.sv
// reg_dump_shadow: one-cycle capture of inst + registers, with an MSB-first byte selector.
module reg_dump_shadow #(
   parameter int NUM_REGS = 32,
   parameter int WORD_W   = 32,
   parameter int SEL_W    = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load,
   input  logic [NUM_REGS*WORD_W-1:0] regs_flat,
   input  logic [WORD_W-1:0]          inst,
   input  logic [SEL_W-1:0]           sel,
   output logic [7:0]                 byte_out
);
   localparam int BPW = WORD_W / 8;
   localparam int WI  = $clog2(NUM_REGS + 1);
   logic [WORD_W-1:0] words [NUM_REGS+1];
   logic [WI-1:0]     w;
   int                b;
   // word 0 is the instruction, words 1..NUM_REGS are reg0..reg(NUM_REGS-1)
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) for (int i = 0; i <= NUM_REGS; i++) words[i] <= '0;
      else if (load) begin
         words[0] <= inst;
         for (int i = 0; i < NUM_REGS; i++) words[i+1] <= regs_flat[i*WORD_W +: WORD_W];
      end
   always_comb begin
      w        = WI'(int'(sel) / BPW);
      b        = int'(sel) % BPW;
      byte_out = 8'(words[w] >> (8 * (BPW - 1 - b)));
   end
endmodule

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: snapshots CPU registers and streams them as a framed, XOR-checksummed byte sequence.
module reg_dump_tx
   import reg_dump_pkg::*;
#(
   parameter int         NUM_REGS  = 32,
   parameter int         WORD_W    = 32,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REGS*WORD_W-1:0] regs_flat,
   input  logic [WORD_W-1:0]          inst,
   input  logic                       snap_req,
   reg_dump_tx_if.master              tx,
   output logic                       busy,
   output logic                       done,
   output logic                       overrun,
   output logic [7:0]                 seq
);
   localparam int FB = frame_bytes(NUM_REGS, WORD_W);
   localparam int IW = idx_w(NUM_REGS, WORD_W);
   state_t        state;
   logic [IW-1:0] idx;
   logic [7:0]    acc;
   logic [7:0]    sbyte;
   logic          hs;
   logic          last;
   assign hs   = tx.tx_valid && tx.tx_ready;
   assign last = idx == IW'(FB - 2);
   // tx_data is registered, so the selector looks one byte ahead: frame byte idx+1 is shadow byte idx-1
   reg_dump_shadow #(.NUM_REGS(NUM_REGS), .WORD_W(WORD_W), .SEL_W(IW)) u_shadow (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == IDLE && snap_req),
      .regs_flat(regs_flat),
      .inst     (inst),
      .sel      (idx - IW'(1)),
      .byte_out (sbyte)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         acc         <= '0;
         tx.tx_data  <= '0;
         tx.tx_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
         seq         <= '0;
      end else begin
         done <= 1'b0;
         if (snap_req && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE: if (snap_req) begin
               state       <= SEND;
               idx         <= '0;
               acc         <= '0;
               tx.tx_data  <= SYNC_BYTE;
               tx.tx_valid <= 1'b1;
               busy        <= 1'b1;
            end
            SEND: if (hs) begin
               idx        <= idx + 1'b1;
               acc        <= acc ^ tx.tx_data;
               tx.tx_data <= last ? acc ^ tx.tx_data : (idx == '0 ? seq : sbyte);
               if (last) state <= CHK;
            end
            CHK: if (hs) begin
               state       <= IDLE;
               tx.tx_data  <= '0;
               tx.tx_valid <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b1;
               seq         <= seq + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx: scoreboard bench for reg_dump_tx; expected frames are queued at capture time.
module tb_reg_dump_tx;
   logic              clk = 0;
   logic              rst_n = 0;
   logic [31:0]       regs [32];
   logic [32*32-1:0]  regs_flat;
   logic [31:0]       inst = 0;
   logic              snap_req = 0;
   logic              busy, done, overrun;
   logic [7:0]        seq;
   reg_dump_tx_if     bus();
   int                checks = 0, errors = 0;
   logic [7:0]        sb [$];
   logic [7:0]        rx [$];
   logic [7:0]        exp_frame [135];
   logic [7:0]        exp_seq = 0;
   int                n;

   reg_dump_tx dut (
      .clk(clk), .rst_n(rst_n), .regs_flat(regs_flat), .inst(inst), .snap_req(snap_req),
      .tx(bus), .busy(busy), .done(done), .overrun(overrun), .seq(seq)
   );

   always #5 clk = ~clk;
   always_comb for (int i = 0; i < 32; i++) regs_flat[i*32 +: 32] = regs[i];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: every handshake pops one expected byte
   always @(negedge clk)
      if (rst_n && bus.tx_valid && bus.tx_ready) begin
         rx.push_back(bus.tx_data);
         if (sb.size() == 0) chk("unexpected_byte", 32'(bus.tx_data), 32'hxx);
         else chk("byte", 32'(bus.tx_data), 32'(sb.pop_front()));
      end

   task automatic push_frame();
      logic [7:0] x;
      exp_frame[0] = 8'hA5;
      exp_frame[1] = exp_seq;
      for (int b = 0; b < 4; b++) exp_frame[2+b] = inst[31-8*b -: 8];
      for (int r = 0; r < 32; r++)
         for (int b = 0; b < 4; b++) exp_frame[6+4*r+b] = regs[r][31-8*b -: 8];
      x = 0;
      for (int i = 0; i < 134; i++) x ^= exp_frame[i];
      exp_frame[134] = x;
      for (int i = 0; i < 135; i++) sb.push_back(exp_frame[i]);
   endtask

   // called at posedge+1; capture happens on the next edge
   task automatic start_frame();
      rx.delete();
      push_frame();
      snap_req = 1;
      @(posedge clk); #1;
      snap_req = 0;
      chk("start_valid", 32'(bus.tx_valid), 1);
      chk("start_sync", 32'(bus.tx_data), 32'hA5);
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!done && cnt < 2000);
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic finish_frame();
      wait_done(n);
      exp_seq++;
      chk("sb_empty", 32'(sb.size()), 0);
      chk("seq_after", 32'(seq), 32'(exp_seq));
   endtask

   initial begin
      bus.tx_ready = 1;
      for (int i = 0; i < 32; i++) regs[i] = 0;
      #12;
      chk("rst_tx_data", 32'(bus.tx_data), 0);
      chk("rst_tx_valid", 32'(bus.tx_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_seq", 32'(seq), 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      // all zero frame
      start_frame();
      chk("busy_in_frame", 32'(busy), 1);
      wait_done(n);
      exp_seq++;
      chk("done_latency", 32'(n), 135);
      chk("t1_len", 32'(rx.size()), 135);
      chk("t1_checksum", 32'(rx[134]), 32'hA5);
      chk("t1_seq", 32'(seq), 1);
      chk("t1_idle_valid", 32'(bus.tx_valid), 0);
      chk("t1_idle_busy", 32'(busy), 0);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 0);

      // single nonzero register, seq reset to 0 first
      rst_n = 0; #1; rst_n = 1; exp_seq = 0;
      regs[5] = 32'h12345678;
      @(posedge clk); #1;
      start_frame();
      finish_frame();
      chk("t2_b26", 32'(rx[26]), 32'h12);
      chk("t2_b27", 32'(rx[27]), 32'h34);
      chk("t2_b28", 32'(rx[28]), 32'h56);
      chk("t2_b29", 32'(rx[29]), 32'h78);
      chk("t2_checksum", 32'(rx[134]), 32'hAD);

      // back-pressure while byte 10 is presented
      inst = 32'hDEADBEEF;
      for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * (i + 1);
      @(posedge clk); #1;
      start_frame();
      repeat (10) begin @(posedge clk); #1; end
      bus.tx_ready = 0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall_data", 32'(bus.tx_data), 32'(exp_frame[10]));
         chk("stall_valid", 32'(bus.tx_valid), 1);
      end
      bus.tx_ready = 1;
      finish_frame();

      // overrun and shadow isolation
      for (int i = 0; i < 32; i++) regs[i] = 32'hCAFE0000 + i;
      inst = 32'h00C0FFEE;
      @(posedge clk); #1;
      start_frame();
      for (int i = 0; i < 32; i++) regs[i] = 32'h5A5A5A5A ^ i;
      inst = 32'hFFFFFFFF;
      repeat (39) begin @(posedge clk); #1; end
      snap_req = 1;
      @(posedge clk); #1;
      snap_req = 0;
      chk("overrun_set", 32'(overrun), 1);
      finish_frame();
      @(posedge clk); #1;
      start_frame();
      finish_frame();
      chk("overrun_sticky", 32'(overrun), 1);

      // reset mid-frame at byte 50
      @(posedge clk); #1;
      start_frame();
      repeat (50) begin @(posedge clk); #1; end
      rst_n = 0;
      #1;
      chk("arst_valid", 32'(bus.tx_valid), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_seq", 32'(seq), 0);
      chk("arst_overrun", 32'(overrun), 0);
      sb.delete();
      repeat (2) begin
         @(posedge clk); #1;
         chk("arst_no_done", 32'(done), 0);
      end
      rst_n = 1;
      exp_seq = 0;
      @(posedge clk); #1;
      start_frame();
      finish_frame();
      chk("post_rst_seqbyte", 32'(rx[1]), 0);

      // 257 back-to-back frames: seq 00..FF then 00
      rst_n = 0; #1; rst_n = 1; exp_seq = 0;
      @(posedge clk); #1;
      push_frame();
      snap_req = 1;
      @(posedge clk); #1;
      for (int f = 0; f < 257; f++) begin
         wait_done(n);
         exp_seq++;
         if (n != 135) chk("b2b_len", 32'(n), 135);
         if (f < 256) push_frame();
         else snap_req = 0;
         chk("b2b_gap", 32'(bus.tx_valid), 0);
         @(posedge clk); #1;
         if (f < 256) chk("b2b_restart", 32'(bus.tx_data), 32'hA5);
         else chk("b2b_stop", 32'(busy), 0);
      end
      chk("b2b_sb_empty", 32'(sb.size()), 0);
      chk("b2b_seq_wrap", 32'(seq), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
